// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-side instruction memory responder.
package fetch_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } fetch_mem_state_t;

    localparam logic [4:0] DATA_TAG = 5'b11111;
    localparam int         WORD_OFS = 2;

    // Words whose low five bits carry the data tag are steered to CDR by Fetch.
    function automatic logic is_data_tag(input word_t w);
        return (w[4:0] == DATA_TAG);
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// 1R1W word storage: combinational read by index, synchronous write; never reset.
module inst_mem_array
    import fetch_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  word_t         wr_data,
    input  logic [AW-1:0] rd_idx,
    output word_t         rd_data
);

    word_t mem_r [DEPTH_WORDS];

    // Preload write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/fetch_mem_responder.sv
// Handshaked instruction-memory responder for Fetch: fixed-latency single-outstanding reads.
// Optional feature macro FETCH_MEM_DATA_TAG_EN adds the registered rsp_is_data output.
module fetch_mem_responder
    import fetch_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
`ifdef FETCH_MEM_DATA_TAG_EN
    ,
    output logic        rsp_is_data
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    fetch_mem_state_t state_r, state_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic             req_ready_r, rsp_valid_r, rsp_err_r;
    word_t            rsp_data_r, rd_data_s;
    logic             accept_s, req_err_s, wr_ok_s;

    // Upper address bits above the index must be zero since DEPTH_WORDS is a power of two.
    assign req_err_s = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+WORD_OFS]);
    assign wr_ok_s   = wr_en && (wr_addr[1:0] == 2'b00) && !(|wr_addr[31:AW+WORD_OFS]);
    assign accept_s  = (state_r == IDLE) && req_valid;

    inst_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_ok_s),
        .wr_idx  (wr_addr[AW+WORD_OFS-1:WORD_OFS]),
        .wr_data (wr_data),
        .rd_idx  (req_addr[AW+WORD_OFS-1:WORD_OFS]),
        .rd_data (rd_data_s)
    );

    // Next-state and latency counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = (LATENCY == 1) ? RESP : BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = RESP;
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, counter and registered response outputs; read data is captured on accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            if (accept_s) begin
                rsp_data_r <= req_err_s ? 32'h0000_0000 : rd_data_s;
                rsp_err_r  <= req_err_s;
            end
        end
    end

`ifdef FETCH_MEM_DATA_TAG_EN
    logic rsp_is_data_r;

    // Data/instruction steering tag, registered alongside rsp_data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_is_data_r <= 1'b0;
        end else if (accept_s) begin
            rsp_is_data_r <= !req_err_s && is_data_tag(rd_data_s);
        end
    end

    assign rsp_is_data = rsp_is_data_r;
`endif

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Self-checking bench for fetch_mem_responder against a word-array reference model.
module tb_fetch_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
`ifdef FETCH_MEM_DATA_TAG_EN
    logic        rsp_is_data;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    fetch_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
`ifdef FETCH_MEM_DATA_TAG_EN
        ,
        .rsp_is_data (rsp_is_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH));
    endfunction

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (addr_ok(a)) mdl[a[11:2]] = d;
    endtask

    // Issue one request and check latency, data, hold stability and handshake.
    task automatic do_req(input logic [31:0] addr, input int hold, input bit noise,
                          input bit wr_same, input logic [31:0] wdata, input string name);
        logic [31:0] exp_d;
        logic        exp_e;
        logic        exp_t;
        int          n;
        exp_e = !addr_ok(addr);
        exp_d = exp_e ? 32'h0 : mdl[addr[11:2]];
        exp_t = !exp_e && (exp_d[4:0] == 5'h1f);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b expected 1", name, req_ready);
        end
        req_valid = 1'b1; req_addr = addr;
        if (wr_same) begin wr_en = 1'b1; wr_addr = addr; wr_data = wdata; end
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        if (wr_same && addr_ok(addr)) mdl[addr[11:2]] = wdata;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL %s ready_busy: got %b expected 0", name, req_ready);
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            if (noise) begin req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom; end
            tick();
            n++;
        end
        checks++;
        if (n != LAT) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", name, n, LAT);
        end
        checks++;
        if (rsp_data !== exp_d || rsp_err !== exp_e) begin
            errors++;
            $display("FAIL %s data: got %h/%b expected %h/%b", name, rsp_data, rsp_err, exp_d, exp_e);
        end
`ifdef FETCH_MEM_DATA_TAG_EN
        checks++;
        if (rsp_is_data !== exp_t) begin
            errors++; $display("FAIL %s tag: got %b expected %b", name, rsp_is_data, exp_t);
        end
`else
        exp_t = 1'b0;
`endif
        for (int i = 0; i < hold; i++) begin
            if (noise) begin req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom; end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_err !== exp_e || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%b d=%h e=%b r=%b expected v=1 d=%h e=%b r=0",
                         name, i, rsp_valid, rsp_data, rsp_err, req_ready, exp_d, exp_e);
            end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: got v=%b r=%b expected v=0 r=1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h e=%b expected 0/0/0", rsp_valid, rsp_data, rsp_err);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got r=%b v=%b expected r=1 v=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_preload();
        for (int i = 0; i < DEPTH; i++) write_word(32'(i * 4), $urandom);
        write_word(32'h0000_0010, 32'hDEAD_BEEF);
        write_word(32'h0000_0011, 32'h5555_AAAA);
    endtask

    task automatic test_basic();
        do_req(32'h0000_0010, 0, 1'b0, 1'b0, 32'h0, "basic");
        do_req(32'h0000_0010, 5, 1'b0, 1'b0, 32'h0, "backpressure");
    endtask

    task automatic test_errors();
        do_req(32'h0000_0013, 1, 1'b0, 1'b0, 32'h0, "misaligned");
        do_req(32'h0000_1000, 1, 1'b0, 1'b0, 32'h0, "out_of_range");
        do_req(32'hFFFF_FFFC, 0, 1'b0, 1'b0, 32'h0, "top_addr");
        do_req(32'h0000_0FFC, 0, 1'b0, 1'b0, 32'h0, "last_word");
    endtask

    task automatic test_reset_mid_busy();
        req_valid = 1'b1; req_addr = 32'h0000_0010;
        tick();
        req_valid = 1'b0;
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 32'h0000_0014; wr_data = 32'hCAFE_F00D;
        tick();
        wr_en = 1'b0; mdl[5] = 32'hCAFE_F00D;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_busy%0d: got v=%b d=%h e=%b r=%b expected 0/0/0/1",
                         i, rsp_valid, rsp_data, rsp_err, req_ready);
            end
            tick();
        end
        do_req(32'h0000_0010, 0, 1'b0, 1'b0, 32'h0, "reread_after_reset");
        do_req(32'h0000_0014, 0, 1'b0, 1'b0, 32'h0, "write_during_reset");
    endtask

    task automatic test_read_before_write();
        do_req(32'h0000_0010, 0, 1'b0, 1'b1, 32'h1234_5678, "rbw_same_cycle");
        do_req(32'h0000_0010, 0, 1'b0, 1'b0, 32'h0, "rbw_next");
    endtask

    task automatic test_back_to_back();
        int n;
        req_valid = 1'b1; req_addr = 32'h0000_0020;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0024;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_release: got v=%b r=%b expected v=0 r=1", rsp_valid, req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got r=%b expected 0", req_ready);
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (n != LAT || rsp_data !== mdl[9] || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d d=%h e=%b expected lat=%0d d=%h e=0",
                     n, rsp_data, rsp_err, LAT, mdl[9]);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0)
                write_word({26'h0, 4'($urandom), 2'($urandom_range(0, 3) == 0 ? 1 : 0)}, $urandom);
            case ($urandom_range(0, 3))
                0: a = {26'h0, 4'($urandom), 2'b00};
                1: a = {26'h0, 4'($urandom), 2'($urandom_range(1, 3))};
                2: a = {$urandom_range(1, 255) << 12} | {20'h0, 10'($urandom), 2'b00};
                default: a = {20'h0, 10'($urandom), 2'b00};
            endcase
            do_req(a, $urandom_range(0, 3), 1'b1, ($urandom_range(0, 3) == 0), $urandom, "random");
        end
    endtask

`ifdef FETCH_MEM_DATA_TAG_EN
    task automatic test_tag();
        write_word(32'h0000_0020, 32'h0000_001F);
        write_word(32'h0000_0024, 32'h0000_0013);
        do_req(32'h0000_0020, 0, 1'b0, 1'b0, 32'h0, "tag_data");
        do_req(32'h0000_0024, 0, 1'b0, 1'b0, 32'h0, "tag_inst");
        do_req(32'h0000_0021, 0, 1'b0, 1'b0, 32'h0, "tag_misaligned");
    endtask
`endif

    initial begin
        test_reset();
        test_preload();
        test_basic();
        test_errors();
        test_reset_mid_busy();
        test_read_before_write();
        test_back_to_back();
`ifdef FETCH_MEM_DATA_TAG_EN
        test_tag();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
